// File: rtl/dmem_wait_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_wait_responder_if
// Brief    : MEM-stage load/store bus between the pipeline and the responder.
// Revision : 1.0
// ============================================================================
interface dmem_wait_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );
endinterface
`default_nettype wire

// File: rtl/dmem_wait_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_wait_responder
// Brief    : Word data memory with fixed wait states and a pipeline stall line.
// Revision : 1.0
// ============================================================================
module dmem_wait_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  wire logic          clk,
  input  wire logic          reset,
  dmem_wait_responder_if.slave bus
);

  localparam int          c_AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] c_DEPTH     = 30'(DEPTH_WORDS);
  localparam logic [3:0]  c_CNT_LOAD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit          c_ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_ready;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic            w_accept;
  logic            w_enter_done;
  logic            w_acc_we;
  logic [31:0]     w_acc_addr;
  logic [31:0]     w_acc_wdata;
  logic            w_err;
  logic [c_AW-1:0] w_idx;
  logic            w_mem_wr;
  logic [31:0]     w_rd_word;

  assign w_accept     = bus.req_valid && r_ready;
  assign w_enter_done = (r_state == S_IDLE && w_accept && c_ZERO_WAIT) ||
                        (r_state == S_BUSY && r_cnt == 4'd0);

  // With zero wait states the memory action shares the acceptance edge, so the
  // live request is used in IDLE and the captured copy otherwise.
  assign w_acc_we    = (r_state == S_IDLE) ? bus.req_we    : r_we;
  assign w_acc_addr  = (r_state == S_IDLE) ? bus.req_addr  : r_addr;
  assign w_acc_wdata = (r_state == S_IDLE) ? bus.req_wdata : r_wdata;

  assign w_err     = (w_acc_addr[1:0] != 2'b00) || (w_acc_addr[31:2] >= c_DEPTH);
  assign w_idx     = w_acc_addr[c_AW+1:2];
  assign w_mem_wr  = w_enter_done && w_acc_we && !w_err && !reset;
  assign w_rd_word = (w_err || w_acc_we) ? 32'd0 : r_mem[w_idx];

  always_ff @(posedge clk) begin
    if (w_mem_wr) begin
      r_mem[w_idx] <= w_acc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we    <= bus.req_we;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_ready <= 1'b0;
            if (c_ZERO_WAIT) begin
              r_state     <= S_DONE;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= w_err;
              r_rsp_rdata <= w_rd_word;
            end else begin
              r_state <= S_BUSY;
              r_cnt   <= c_CNT_LOAD;
            end
          end
        end
        S_BUSY: begin
          if (w_enter_done) begin
            r_state     <= S_DONE;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rsp_rdata <= w_rd_word;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_ready     <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= 32'd0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_ready     <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= 32'd0;
        end
      endcase
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.stall     = (r_state == S_BUSY) || (r_state == S_IDLE && bus.req_valid);

endmodule
`default_nettype wire

// File: tb/tb_dmem_wait_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_wait_responder
// Brief    : Two responders (2 and 0 wait states) against a timeline model.
// Revision : 1.0
// ============================================================================
module tb_dmem_wait_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [2];
  logic        v_valid [2];
  logic        v_we    [2];
  logic [31:0] v_addr  [2];
  logic [31:0] v_wdata [2];
  logic        o_ready [2];
  logic        o_rvalid[2];
  logic        o_err   [2];
  logic        o_stall [2];
  logic [31:0] o_rdata [2];

  dmem_wait_responder_if bus0 ();
  dmem_wait_responder_if bus1 ();

  assign bus0.req_valid = v_valid[0];
  assign bus0.req_we    = v_we[0];
  assign bus0.req_addr  = v_addr[0];
  assign bus0.req_wdata = v_wdata[0];
  assign bus1.req_valid = v_valid[1];
  assign bus1.req_we    = v_we[1];
  assign bus1.req_addr  = v_addr[1];
  assign bus1.req_wdata = v_wdata[1];
  assign o_ready[0]  = bus0.req_ready;
  assign o_rvalid[0] = bus0.rsp_valid;
  assign o_err[0]    = bus0.rsp_err;
  assign o_stall[0]  = bus0.stall;
  assign o_rdata[0]  = bus0.rsp_rdata;
  assign o_ready[1]  = bus1.req_ready;
  assign o_rvalid[1] = bus1.rsp_valid;
  assign o_err[1]    = bus1.rsp_err;
  assign o_stall[1]  = bus1.stall;
  assign o_rdata[1]  = bus1.rsp_rdata;

  dmem_wait_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .reset(rst[0]), .bus(bus0.slave)
  );
  dmem_wait_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .reset(rst[1]), .bus(bus1.slave)
  );

  // Model: an accepted access at cycle N responds in cycle N+W+1; anything
  // between is busy. Storage is a plain array per instance.
  int          W [2] = '{2, 0};
  bit          pend [2];
  int          rcyc [2];
  int          acyc [2];
  int          prev_acyc [2];
  bit          pwe [2];
  logic [31:0] paddr [2];
  logic [31:0] pwdata [2];
  logic [31:0] mm [2][256];
  bit          kn [2][256];
  int          acc_cnt [2];
  int          mrsp_cnt [2];
  int          drsp_cnt [2];
  logic [31:0] obs_rdata [2];
  logic        obs_err [2];
  int          obs_cyc [2];
  int          cyc = 0;
  bit          started = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        bit          inres;
        bit          err;
        bit          rd_known;
        logic [31:0] exp_rd;
        inres    = pend[k] && (cyc == rcyc[k]);
        err      = 1'b0;
        rd_known = 1'b1;
        exp_rd   = 32'd0;
        if (inres) begin
          err = (paddr[k][1:0] != 2'b00) || (paddr[k][31:2] >= 30'd256);
          if (!err && !pwe[k]) begin
            exp_rd   = mm[k][paddr[k][9:2]];
            rd_known = kn[k][paddr[k][9:2]];
          end
          if (!err && pwe[k]) begin
            mm[k][paddr[k][9:2]] = pwdata[k];
            kn[k][paddr[k][9:2]] = 1'b1;
          end
          mrsp_cnt[k]++;
        end
        chk("req_ready", k, {31'd0, o_ready[k]}, {31'd0, !pend[k]});
        chk("stall", k, {31'd0, o_stall[k]},
            {31'd0, (pend[k] && !inres) || (!pend[k] && v_valid[k])});
        chk("rsp_valid", k, {31'd0, o_rvalid[k]}, {31'd0, inres});
        chk("rsp_err", k, {31'd0, o_err[k]}, {31'd0, err});
        if (rd_known) chk("rsp_rdata", k, o_rdata[k], exp_rd);
        if (o_rvalid[k] === 1'b1) begin
          drsp_cnt[k]++;
          obs_rdata[k] = o_rdata[k];
          obs_err[k]   = o_err[k];
          obs_cyc[k]   = cyc;
        end
        if (rst[k]) begin
          pend[k] = 1'b0;
        end else if (inres) begin
          pend[k] = 1'b0;
        end else if (!pend[k] && v_valid[k]) begin
          pend[k]      = 1'b1;
          prev_acyc[k] = acyc[k];
          acyc[k]      = cyc;
          rcyc[k]      = cyc + W[k] + 1;
          pwe[k]       = v_we[k];
          paddr[k]     = v_addr[k];
          pwdata[k]    = v_wdata[k];
          acc_cnt[k]++;
        end
      end
    end
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_accept(input int k, input int a0);
    int n = 0;
    while (acc_cnt[k] == a0 && n < 40) begin
      tick(1);
      n++;
    end
    v_valid[k] = 1'b0;
    if (acc_cnt[k] == a0) chk("accept_timeout", k, 32'd0, 32'd1);
  endtask

  task automatic access(input int k, input bit we, input logic [31:0] a,
                        input logic [31:0] d);
    int a0 = acc_cnt[k];
    int r0 = mrsp_cnt[k];
    int n  = 0;
    obs_cyc[k] = -100;
    v_we[k]    = we;
    v_addr[k]  = a;
    v_wdata[k] = d;
    v_valid[k] = 1'b1;
    wait_accept(k, a0);
    while (mrsp_cnt[k] == r0 && n < 40) begin
      tick(1);
      n++;
    end
    if (mrsp_cnt[k] == r0) chk("response_timeout", k, 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] pick_addr();
    int r = $urandom_range(0, 15);
    logic [31:0] w = (r < 8) ? 32'(r) : 32'd255;
    if (r < 10)  return w << 2;
    if (r < 12)  return (w << 2) | 32'($urandom_range(1, 3));
    if (r < 14)  return 32'h400 + (32'($urandom_range(0, 1023)) << 2);
    if (r == 14) return 32'hFFFF_FFFC;
    return 32'h3FC;
  endfunction

  initial begin
    int d0;
    int a0;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; v_valid[k] = 1'b0; v_we[k] = 1'b0;
      v_addr[k] = 32'd0; v_wdata[k] = 32'd0;
      pend[k] = 1'b0; acc_cnt[k] = 0; mrsp_cnt[k] = 0; drsp_cnt[k] = 0;
      acyc[k] = 0; prev_acyc[k] = 0; obs_cyc[k] = -100;
      for (int i = 0; i < 256; i++) kn[k][i] = 1'b0;
    end
    tick(2);
    started = 1'b1;
    tick(1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    tick(1);

    for (int k = 0; k < 2; k++) begin
      access(k, 1'b1, 32'h10, 32'hDEAD_BEEF);
      chk("lit_wr_err", k, {31'd0, obs_err[k]}, 32'd0);
      chk("lit_wr_rdata", k, obs_rdata[k], 32'd0);
      chk("lit_latency", k, 32'(obs_cyc[k] - acyc[k]), (k == 0) ? 32'd3 : 32'd1);
      access(k, 1'b0, 32'h10, 32'd0);
      chk("lit_rd_10", k, obs_rdata[k], 32'hDEAD_BEEF);
      access(k, 1'b1, 32'h0, 32'h0BAD_F00D);
      access(k, 1'b0, 32'h13, 32'd0);
      chk("lit_misalign_err", k, {31'd0, obs_err[k]}, 32'd1);
      chk("lit_misalign_rdata", k, obs_rdata[k], 32'd0);
      access(k, 1'b1, 32'h400, 32'h1234_5678);
      chk("lit_oob_err", k, {31'd0, obs_err[k]}, 32'd1);
      access(k, 1'b0, 32'h0, 32'd0);
      chk("lit_word0_kept", k, obs_rdata[k], 32'h0BAD_F00D);
      access(k, 1'b1, 32'h3FC, 32'hA5A5_A5A5);
      chk("lit_top_err", k, {31'd0, obs_err[k]}, 32'd0);
      access(k, 1'b0, 32'h3FC, 32'd0);
      chk("lit_top_rd", k, obs_rdata[k], 32'hA5A5_A5A5);
      // Held request: consecutive acceptances are W+2 cycles apart.
      v_we[k] = 1'b0; v_addr[k] = 32'h3FC; v_valid[k] = 1'b1;
      tick(12);
      v_valid[k] = 1'b0;
      tick(6);
      chk("lit_b2b_gap", k, 32'(acyc[k] - prev_acyc[k]), (k == 0) ? 32'd4 : 32'd2);
    end

    // Reset in the first BUSY cycle drops the pending write.
    access(0, 1'b1, 32'h20, 32'h1111_1111);
    d0 = drsp_cnt[0];
    a0 = acc_cnt[0];
    v_we[0] = 1'b1; v_addr[0] = 32'h20; v_wdata[0] = 32'hCAFE_F00D; v_valid[0] = 1'b1;
    wait_accept(0, a0);
    rst[0] = 1'b1;
    tick(1);
    rst[0] = 1'b0;
    tick(5);
    chk("lit_rst_no_rsp", 0, 32'(drsp_cnt[0] - d0), 32'd0);
    access(0, 1'b0, 32'h20, 32'd0);
    chk("lit_rst_kept", 0, obs_rdata[0], 32'h1111_1111);

    repeat (3000) begin
      for (int k = 0; k < 2; k++) begin
        rst[k]     = ($urandom_range(0, 79) == 0);
        v_valid[k] = ($urandom_range(0, 2) != 0);
        v_we[k]    = $urandom_range(0, 1) == 1;
        v_addr[k]  = pick_addr();
        v_wdata[k] = $urandom;
      end
      tick(1);
    end
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0;
      v_valid[k] = 1'b0;
    end
    tick(6);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
